// File: rtl/rm1_dec_pkg.sv
// Shared definitions for the RM(1,M) Fast-Hadamard-Transform decoder.
// Holds the controller state encoding, the width helpers used to size the
// spectrum and count datapaths, and the RM(1,M) codeword-bit function. That
// function is used by the optional re-encoder (RM1_DEC_CODEWORD_OUT_EN) and
// is also available to a reference model.
package rm1_dec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FHT,
    SEARCH,
    DONE
  } state_t;

  // Block length N = 2^M.
  function automatic int n_of(input int m);
    return 1 << m;
  endfunction

  // Spectrum values span [-N, +N], so they need M+2 signed bits.
  function automatic int spec_w(input int m);
    return m + 2;
  endfunction

  // Magnitudes (0..N) and corrected-bit counts need M+1 unsigned bits.
  function automatic int cnt_w(input int m);
    return m + 1;
  endfunction

  // Codeword bit j of RM(1,m) for message msg (msg[m] = constant term,
  // msg[m-1:0] = linear coefficients): msg[m] ^ parity(msg[m-1:0] & j).
  function automatic logic rm1_code_bit(input int m, input logic [8:0] msg,
                                        input int j);
    logic [7:0] lin;
    lin = msg[7:0] & 8'((1 << m) - 1);
    return msg[m[3:0]] ^ (^(lin & 8'(j)));
  endfunction

endpackage

// File: rtl/rm1_fht_decoder_if.sv
// Handshake bundle for rm1_fht_decoder.
//   in_valid / in_ready / in_codeword[N-1:0]         : codeword input channel
//   out_valid / out_ready                             : result channel
//   out_message[M:0], out_err_count[M:0], out_tie     : decode result
//   out_codeword[N-1:0]                               : only with RM1_DEC_CODEWORD_OUT_EN
// Modport slave is the decoder side, master is the producer/consumer side.
interface rm1_fht_decoder_if
  import rm1_dec_pkg::*;
#(
  parameter int M = 4
);
  localparam int N = n_of(M);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_codeword;
  logic         out_valid;
  logic         out_ready;
  logic [M:0]   out_message;
  logic [M:0]   out_err_count;
  logic         out_tie;
`ifdef RM1_DEC_CODEWORD_OUT_EN
  logic [N-1:0] out_codeword;
`endif

  modport slave (
    input  in_valid, in_codeword, out_ready,
    output in_ready, out_valid, out_message, out_err_count,
`ifdef RM1_DEC_CODEWORD_OUT_EN
    output out_codeword,
`endif
    output out_tie
  );

  modport master (
    output in_valid, in_codeword, out_ready,
    input  in_ready, out_valid, out_message, out_err_count,
`ifdef RM1_DEC_CODEWORD_OUT_EN
    input  out_codeword,
`endif
    input  out_tie
  );

endinterface

// File: rtl/rm1_fht_stage.sv
// One butterfly stage of an N-point Fast Hadamard Transform, purely
// combinational. The stage index selects the pair stride 2^stage; for each
// pair (a at the lower index, b at index + stride): a' = a + b, b' = a - b.
// Ports:
//   stage : butterfly stage index, 0..M-1
//   y_i   : N signed spectrum values in
//   y_o   : N signed spectrum values out
module rm1_fht_stage
  import rm1_dec_pkg::*;
#(
  parameter  int M = 4,
  localparam int N = n_of(M),
  localparam int W = spec_w(M)
) (
  input  logic [3:0]          stage,
  input  logic signed [W-1:0] y_i [N],
  output logic signed [W-1:0] y_o [N]
);

  always_comb begin
    for (int j = 0; j < N; j++) begin
      int partner;
      partner = (j ^ (1 << stage)) & (N - 1);
      if (((j >> stage) & 1) == 0) begin
        y_o[j] = y_i[j] + y_i[partner];
      end else begin
        y_o[j] = y_i[partner] - y_i[j];
      end
    end
  end

endmodule

// File: rtl/rm1_fht_decoder.sv
// Sequential maximum-likelihood decoder for RM(1,M), N = 2^M.
// A word is accepted in IDLE, mapped to +/-1, transformed with M FHT stages
// (one per cycle, single time-multiplexed stage), then the spectrum is
// scanned one entry per cycle for the peak magnitude. The peak index gives
// the linear coefficients, its sign the constant term; (N - |peak|)/2 is
// the number of corrected bits. Equal peaks set the tie flag and keep the
// lower index.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : rm1_fht_decoder_if.slave (input handshake + result handshake)
// Optional build macro RM1_DEC_CODEWORD_OUT_EN adds bus.out_codeword, the
// re-encoded corrected codeword, valid alongside out_valid.
module rm1_fht_decoder
  import rm1_dec_pkg::*;
#(
  parameter int M = 4
) (
  input logic                    clk,
  input logic                    rst,
  rm1_fht_decoder_if.slave       bus
);

  localparam int N  = n_of(M);
  localparam int SW = spec_w(M);
  localparam int CW = cnt_w(M);

  state_t               state_q, state_d;
  logic signed [SW-1:0] y_q [N];
  logic signed [SW-1:0] y_d [N];
  logic signed [SW-1:0] y_stage [N];
  logic [3:0]           stage_q, stage_d;
  logic [M-1:0]         k_q, k_d;
  logic [CW-1:0]        best_mag_q, best_mag_d;
  logic [M-1:0]         best_idx_q, best_idx_d;
  logic                 best_neg_q, best_neg_d;
  logic                 tie_q, tie_d;
  logic                 out_valid_q, out_valid_d;
  logic [M:0]           out_message_q, out_message_d;
  logic [CW-1:0]        out_err_q, out_err_d;
  logic                 out_tie_q, out_tie_d;
  logic                 in_ready;
  logic signed [SW-1:0] cur;
  logic [CW-1:0]        cur_mag;

  // |v| for v in [-N, +N]; fits CW unsigned bits.
  function automatic logic [CW-1:0] magnitude(input logic signed [SW-1:0] v);
    return CW'(v[SW-1] ? -v : v);
  endfunction

  rm1_fht_stage #(.M(M)) u_stage (
    .stage (stage_q),
    .y_i   (y_q),
    .y_o   (y_stage)
  );

  // Combinational so that in_ready is low during the reset cycle itself.
  assign in_ready = (state_q == IDLE) && !rst;
  assign cur      = y_q[k_q];
  assign cur_mag  = magnitude(cur);

  always_comb begin
    state_d       = state_q;
    y_d           = y_q;
    stage_d       = stage_q;
    k_d           = k_q;
    best_mag_d    = best_mag_q;
    best_idx_d    = best_idx_q;
    best_neg_d    = best_neg_q;
    tie_d         = tie_q;
    out_valid_d   = out_valid_q;
    out_message_d = out_message_q;
    out_err_d     = out_err_q;
    out_tie_d     = out_tie_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready) begin
          for (int j = 0; j < N; j++) begin
            y_d[j] = bus.in_codeword[j] ? {SW{1'b1}} : SW'(1);
          end
          stage_d = '0;
          state_d = FHT;
        end
      end
      FHT: begin
        y_d     = y_stage;
        stage_d = stage_q + 4'd1;
        if (stage_q == 4'(M - 1)) begin
          k_d     = '0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        // Entry 0 seeds the search; later entries replace only on a strictly
        // larger magnitude, so ties keep the lower index.
        if (k_q == '0 || cur_mag > best_mag_q) begin
          best_mag_d = cur_mag;
          best_idx_d = k_q;
          best_neg_d = cur[SW-1];
          tie_d      = 1'b0;
        end else if (cur_mag == best_mag_q) begin
          tie_d = 1'b1;
        end
        k_d = k_q + M'(1);
        if (k_q == {M{1'b1}}) begin
          out_valid_d   = 1'b1;
          out_message_d = {best_neg_d, best_idx_d};
          out_err_d     = (CW'(N) - best_mag_d) >> 1;
          out_tie_d     = tie_d;
          state_d       = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and visible result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      stage_q       <= '0;
      k_q           <= '0;
      out_valid_q   <= 1'b0;
      out_message_q <= '0;
      out_err_q     <= '0;
      out_tie_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      k_q           <= k_d;
      out_valid_q   <= out_valid_d;
      out_message_q <= out_message_d;
      out_err_q     <= out_err_d;
      out_tie_q     <= out_tie_d;
    end
  end

  // Datapath registers: contents are don't-care until loaded by the FSM.
  always_ff @(posedge clk) begin
    y_q        <= y_d;
    best_mag_q <= best_mag_d;
    best_idx_q <= best_idx_d;
    best_neg_q <= best_neg_d;
    tie_q      <= tie_d;
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_message   = out_message_q;
  assign bus.out_err_count = out_err_q;
  assign bus.out_tie       = out_tie_q;

`ifdef RM1_DEC_CODEWORD_OUT_EN
  logic [N-1:0] out_codeword_q, out_codeword_d;

  // Re-encoding the next message every cycle keeps the codeword in lockstep
  // with out_message; encode(0) = 0 matches the reset value.
  always_comb begin
    out_codeword_d = '0;
    for (int j = 0; j < N; j++) begin
      out_codeword_d[j] = rm1_code_bit(M, 9'(out_message_d), j);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_codeword_q <= '0;
    end else begin
      out_codeword_q <= out_codeword_d;
    end
  end

  assign bus.out_codeword = out_codeword_q;
`endif

endmodule
